enemy_collision_ctrl: RTL

//  Per-pixel collision detector and life-state controller for one enemy sprite. Sits directly

---
 rtl/enemy_collision_if.sv | 26 ++
 rtl/enemy_collision_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/enemy_collision_if.sv
// Pixel-overlap inputs and frame-event outputs between the scene logic and the enemy collision controller.
interface enemy_collision_if;
  logic       startOfFrame;
  logic       enemyDR;
  logic       wallDR;
  logic       peerDR;
  logic       shotDR;
  logic       playerDR;
  logic       respawn;
  logic       changeDirection;
  logic       enemyHit;
  logic       playerHit;
  logic       enemyKilled;
  logic       enemyVisible;
  logic [3:0] hitPoints;

  modport master (
    output startOfFrame, enemyDR, wallDR, peerDR, shotDR, playerDR, respawn,
    input  changeDirection, enemyHit, playerHit, enemyKilled, enemyVisible, hitPoints
  );

  modport slave (
    input  startOfFrame, enemyDR, wallDR, peerDR, shotDR, playerDR, respawn,
    output changeDirection, enemyHit, playerHit, enemyKilled, enemyVisible, hitPoints
  );
endinterface

// File: rtl/enemy_collision_ctrl.sv
// Enemy collision detector and life FSM: latches per-pixel overlaps during a frame, evaluates them
// once per startOfFrame, emits one-cycle event pulses and gates the enemy's visibility while dying.
module enemy_collision_ctrl #(
  parameter int HIT_POINTS   = 3,
  parameter int DIR_COOLDOWN = 4,
  parameter int DYING_FRAMES = 16,
  parameter int BLINK_PERIOD = 4
) (
  input  logic               clk,
  input  logic               reset,
  enemy_collision_if.slave   bus
);

  localparam int CD_W      = $clog2(DIR_COOLDOWN + 1);
  localparam int FC_W      = $clog2(DYING_FRAMES + 1);
  localparam int BLINK_BIT = $clog2(BLINK_PERIOD);

  localparam logic [3:0]      HP_INIT   = 4'(HIT_POINTS);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(DIR_COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE    = CD_W'(1);
  localparam logic [FC_W-1:0] FC_LAST   = FC_W'(DYING_FRAMES);
  localparam logic [FC_W-1:0] FC_ONE    = FC_W'(1);

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    DYING = 2'd1,
    DEAD  = 2'd2
  } state_t;

  // Flag vector layout: {player, shot, peer, wall}
  localparam int F_WALL   = 0;
  localparam int F_PEER   = 1;
  localparam int F_SHOT   = 2;
  localparam int F_PLAYER = 3;

  state_t          state;
  logic [3:0]      flags;
  logic [3:0]      hp;
  logic [CD_W-1:0] cooldown;
  logic [FC_W-1:0] frame_cnt;
  logic            change_dir;
  logic            enemy_hit;
  logic            player_hit;
  logic            enemy_killed;
  logic            visible;

  logic [3:0]      overlap;
  logic [3:0]      hp_dec;
  logic            killed;
  logic            turn;
  logic [FC_W-1:0] frame_inc;

  assign overlap   = {4{bus.enemyDR}} & {bus.playerDR, bus.shotDR, bus.peerDR, bus.wallDR};
  assign hp_dec    = (hp == 4'd0) ? 4'd0 : hp - 4'd1;
  assign killed    = flags[F_SHOT] && (hp_dec == 4'd0);
  // A kill suppresses the turn so the corpse does not reverse on its way out.
  assign turn      = (flags[F_WALL] | flags[F_PEER]) && (cooldown == '0) && !killed;
  assign frame_inc = frame_cnt + FC_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ALIVE;
      flags        <= 4'd0;
      hp           <= HP_INIT;
      cooldown     <= '0;
      frame_cnt    <= '0;
      change_dir   <= 1'b0;
      enemy_hit    <= 1'b0;
      player_hit   <= 1'b0;
      enemy_killed <= 1'b0;
      visible      <= 1'b1;
    end else begin
      change_dir   <= 1'b0;
      enemy_hit    <= 1'b0;
      player_hit   <= 1'b0;
      enemy_killed <= 1'b0;

      if (bus.respawn) begin
        state     <= ALIVE;
        flags     <= 4'd0;
        hp        <= HP_INIT;
        cooldown  <= '0;
        frame_cnt <= '0;
        visible   <= 1'b1;
      end else begin
        case (state)
          ALIVE: begin
            if (bus.startOfFrame) begin
              // Decide on last frame's flags; this cycle's overlap opens the new frame.
              flags      <= overlap;
              enemy_hit  <= flags[F_SHOT];
              player_hit <= flags[F_PLAYER];
              if (flags[F_SHOT]) begin
                hp <= hp_dec;
              end
              if (turn) begin
                change_dir <= 1'b1;
                cooldown   <= CD_LOAD;
              end else if (cooldown != '0) begin
                cooldown <= cooldown - CD_ONE;
              end
              if (killed) begin
                enemy_killed <= 1'b1;
                state        <= DYING;
                flags        <= 4'd0;
                frame_cnt    <= '0;
                visible      <= 1'b1;
              end
            end else begin
              flags <= flags | overlap;
            end
          end

          DYING: begin
            flags <= 4'd0;
            if (bus.startOfFrame) begin
              frame_cnt <= frame_inc;
              if (frame_inc == FC_LAST) begin
                state   <= DEAD;
                visible <= 1'b0;
              end else begin
                visible <= ~frame_inc[BLINK_BIT];
              end
            end
          end

          DEAD: begin
            flags   <= 4'd0;
            visible <= 1'b0;
          end

          default: begin
            state   <= DEAD;
            flags   <= 4'd0;
            visible <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.changeDirection = change_dir;
  assign bus.enemyHit        = enemy_hit;
  assign bus.playerHit       = player_hit;
  assign bus.enemyKilled     = enemy_killed;
  assign bus.enemyVisible    = visible;
  assign bus.hitPoints       = hp;

endmodule
